// File: rtl/patch_reducer_scheduler_pkg.sv
// Shared types and helpers for the patch-row reducer pool scheduler.
// No logic of its own; consumed by the interface, arbiter and top.
// Per-reducer life cycle: FREE -> BUSY (init issued) -> HELD (sum captured) -> FREE.
package patch_reducer_scheduler_pkg;

    // Per-reducer state; encodings are fixed so they read the same in waveforms
    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HELD = 2'd2
    } red_state_e;

    // Ceiling log2, used to size reducer indices and owner fields
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/patch_reducer_scheduler_if.sv
// Bundle of config, reducer-pool and result-stream signals for the scheduler.
// Pure wiring, no latency.
// cfg_valid/cfg_ack and out_valid/out_ack are valid/ack handshakes; red_* are pulses.
interface patch_reducer_scheduler_if #(
    parameter int N_PATCH_REDUCER = 4,
    parameter int APP_DATA_WIDTH  = 256,
    parameter int N_ROW_SIZE      = 11,
    parameter int FP_SIZE         = 32,
    parameter int IDX_W           = patch_reducer_scheduler_pkg::log2(N_PATCH_REDUCER)
) ();
    // config stream from DRAM
    logic                               cfg_valid;
    logic [N_ROW_SIZE-1:0]              cfg_row;
    logic [APP_DATA_WIDTH-1:0]          cfg_data;
    logic                               cfg_ack;
    // reducer pool
    logic [N_PATCH_REDUCER-1:0]         red_init;
    logic [N_ROW_SIZE-1:0]              red_n_row;
    logic [APP_DATA_WIDTH-1:0]          red_config_data;
    logic [N_PATCH_REDUCER-1:0]         red_sum_rdy;
    logic [N_PATCH_REDUCER*FP_SIZE-1:0] red_sum;
    logic [N_PATCH_REDUCER*IDX_W-1:0]   red_owner;
    // result stream toward the patch accumulator
    logic                               out_valid;
    logic [FP_SIZE-1:0]                 out_sum;
    logic [IDX_W-1:0]                   out_owner;
    logic [IDX_W-1:0]                   out_src;
    logic                               out_ack;
    // status
    logic [IDX_W:0]                     n_busy;
    logic                               err_spurious;

    modport master (
        input  cfg_valid, cfg_row, cfg_data, red_sum_rdy, red_sum, red_owner, out_ack,
        output cfg_ack, red_init, red_n_row, red_config_data,
               out_valid, out_sum, out_owner, out_src, n_busy, err_spurious
    );

    modport slave (
        output cfg_valid, cfg_row, cfg_data, red_sum_rdy, red_sum, red_owner, out_ack,
        input  cfg_ack, red_init, red_n_row, red_config_data,
               out_valid, out_sum, out_owner, out_src, n_busy, err_spurious
    );

endinterface

// File: rtl/patch_reducer_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant and index of the first request at or after the pointer.
// Grant is combinational; pointer moves to grant+1 on the edge where advance is high.
// No backpressure of its own; the caller only strobes advance when the grant is consumed.
module rr_arbiter
    import patch_reducer_scheduler_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = log2(N)
) (
    input  logic             dram_clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Scan requests starting at the pointer; N is a power of two so the index wraps for free
    always_comb begin
        logic [IDX_W-1:0] idx;
        logic             found;
        idx     = '0;
        found   = 1'b0;
        gnt     = '0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr_q + IDX_W'(i);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt_idx  = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

    // Next search begins just after the index that was granted
    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = gnt_idx + IDX_W'(1);
    end

    // Pointer register
    always_ff @(posedge dram_clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/patch_reducer_scheduler.sv
// Allocates config words to a pool of row reducers and drains their sums round-robin.
// Latency: cfg accept -> red_init next cycle; sum_rdy -> out_valid two cycles later.
// cfg_ack drops when no reducer is free; output register holds until out_ack.
module patch_reducer_scheduler
    import patch_reducer_scheduler_pkg::*;
#(
    parameter int N_PATCH_REDUCER = 4,
    parameter int APP_DATA_WIDTH  = 256,
    parameter int N_ROW_SIZE      = 11,
    parameter int FP_SIZE         = 32
) (
    input  logic                      dram_clk,
    input  logic                      reset_n,
    patch_reducer_scheduler_if.master bus
);
    localparam int N     = N_PATCH_REDUCER;
    localparam int IDX_W = log2(N_PATCH_REDUCER);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    red_state_e                state_q [N];
    red_state_e                state_d [N];
    logic [FP_SIZE-1:0]        hold_sum_q [N];
    logic [FP_SIZE-1:0]        hold_sum_d [N];
    logic [IDX_W-1:0]          hold_own_q [N];
    logic [IDX_W-1:0]          hold_own_d [N];
    logic [N-1:0]              red_init_q, red_init_d;
    logic [N_ROW_SIZE-1:0]     red_n_row_q, red_n_row_d;
    logic [APP_DATA_WIDTH-1:0] red_cfg_q, red_cfg_d;
    logic                      out_valid_q, out_valid_d;
    logic [FP_SIZE-1:0]        out_sum_q, out_sum_d;
    logic [IDX_W-1:0]          out_owner_q, out_owner_d;
    logic [IDX_W-1:0]          out_src_q, out_src_d;
    logic                      err_q, err_d;

    logic [N-1:0]              free_vec, held_vec, alloc_oh, gnt;
    logic [IDX_W-1:0]          gnt_idx;
    logic                      accept, out_load, advance;
    logic [CNT_W-1:0]          n_busy_cnt;

    // Decode per-reducer state into FREE/HELD vectors and count occupied reducers
    always_comb begin
        free_vec   = '0;
        held_vec   = '0;
        n_busy_cnt = '0;
        for (int k = 0; k < N; k++) begin
            free_vec[k] = (state_q[k] == ST_FREE);
            held_vec[k] = (state_q[k] == ST_HELD);
            if (state_q[k] != ST_FREE) n_busy_cnt = n_busy_cnt + CNT_W'(1);
        end
    end

    // Lowest-index free reducer wins allocation (isolate lowest set bit)
    assign alloc_oh = free_vec & (~free_vec + ONE);
    assign accept   = bus.cfg_valid & (|free_vec);
    // Output register refills when empty or being consumed this cycle
    assign out_load = ~out_valid_q | bus.out_ack;
    assign advance  = out_load & (|held_vec);

    rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_rr_arbiter (
        .dram_clk (dram_clk),
        .reset_n  (reset_n),
        .req      (held_vec),
        .advance  (advance),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    // Reducer life cycle: allocation, sum capture and drain target disjoint reducers
    always_comb begin
        state_d = state_q;
        for (int k = 0; k < N; k++) begin
            if (accept && alloc_oh[k])                        state_d[k] = ST_BUSY;
            if (bus.red_sum_rdy[k] && state_q[k] == ST_BUSY)  state_d[k] = ST_HELD;
            if (advance && gnt[k])                            state_d[k] = ST_FREE;
        end
    end

    // Reducer state register
    always_ff @(posedge dram_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) state_q[k] <= ST_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath next values: init pulse, sum holding registers, output register, error flag
    always_comb begin
        hold_sum_d  = hold_sum_q;
        hold_own_d  = hold_own_q;
        red_init_d  = '0;
        red_n_row_d = red_n_row_q;
        red_cfg_d   = red_cfg_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_owner_d = out_owner_q;
        out_src_d   = out_src_q;
        err_d       = err_q;
        if (accept) begin
            red_init_d  = alloc_oh;
            red_n_row_d = bus.cfg_row;
            red_cfg_d   = bus.cfg_data;
        end
        for (int k = 0; k < N; k++) begin
            if (bus.red_sum_rdy[k]) begin
                if (state_q[k] == ST_BUSY) begin
                    hold_sum_d[k] = bus.red_sum[k*FP_SIZE +: FP_SIZE];
                    hold_own_d[k] = bus.red_owner[k*IDX_W +: IDX_W];
                end else begin
                    // a pulse from an idle or already-held reducer is dropped and flagged
                    err_d = 1'b1;
                end
            end
        end
        if (out_load) begin
            out_valid_d = advance;
            if (advance) begin
                out_sum_d   = hold_sum_q[gnt_idx];
                out_owner_d = hold_own_q[gnt_idx];
                out_src_d   = gnt_idx;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge dram_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                hold_sum_q[k] <= '0;
                hold_own_q[k] <= '0;
            end
            red_init_q  <= '0;
            red_n_row_q <= '0;
            red_cfg_q   <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_owner_q <= '0;
            out_src_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            hold_sum_q  <= hold_sum_d;
            hold_own_q  <= hold_own_d;
            red_init_q  <= red_init_d;
            red_n_row_q <= red_n_row_d;
            red_cfg_q   <= red_cfg_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_owner_q <= out_owner_d;
            out_src_q   <= out_src_d;
            err_q       <= err_d;
        end
    end

    assign bus.cfg_ack         = |free_vec;
    assign bus.red_init        = red_init_q;
    assign bus.red_n_row       = red_n_row_q;
    assign bus.red_config_data = red_cfg_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_sum         = out_sum_q;
    assign bus.out_owner       = out_owner_q;
    assign bus.out_src         = out_src_q;
    assign bus.n_busy          = n_busy_cnt;
    assign bus.err_spurious    = err_q;

endmodule

// File: tb/tb_patch_reducer_scheduler.sv
// Self-checking bench for patch_reducer_scheduler: directed scenarios plus a random run
// against a behavioural pool model. Inputs change 1ns after the rising edge and
// outputs are sampled there too, away from the active edge.
`timescale 1ns/1ps
module tb_patch_reducer_scheduler;
    localparam int N  = 4;
    localparam int AW = 256;
    localparam int RW = 11;
    localparam int FW = 32;
    localparam int IW = 2;
    localparam int CW = 3;

    logic dram_clk = 1'b0;
    logic reset_n  = 1'b0;
    always #5 dram_clk = ~dram_clk;

    patch_reducer_scheduler_if #(.N_PATCH_REDUCER(N), .APP_DATA_WIDTH(AW),
                                 .N_ROW_SIZE(RW), .FP_SIZE(FW)) bus ();

    patch_reducer_scheduler #(.N_PATCH_REDUCER(N), .APP_DATA_WIDTH(AW),
                              .N_ROW_SIZE(RW), .FP_SIZE(FW)) dut (
        .dram_clk (dram_clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge dram_clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_data();
        logic [AW-1:0] r;
        for (int i = 0; i < AW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_sum(input int k, input logic [FW-1:0] s, input logic [IW-1:0] o);
        bus.red_sum[k*FW +: FW]   = s;
        bus.red_owner[k*IW +: IW] = o;
    endtask

    task automatic idle_inputs();
        bus.cfg_valid   = 1'b0;
        bus.cfg_row     = '0;
        bus.cfg_data    = '0;
        bus.red_sum_rdy = '0;
        bus.red_sum     = '0;
        bus.red_owner   = '0;
        bus.out_ack     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Offer config words until every reducer of an empty pool is allocated
    task automatic fill_pool();
        bus.cfg_valid = 1'b1;
        repeat (N) begin
            bus.cfg_row  = RW'($urandom);
            bus.cfg_data = rand_data();
            tick();
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        n_vec++; if ({bus.out_valid, bus.out_sum, bus.out_owner, bus.out_src} !== '0) begin
            n_err++; $display("FAIL reset_out got v=%b sum=%h own=%0d src=%0d want all 0",
                              bus.out_valid, bus.out_sum, bus.out_owner, bus.out_src); end
        n_vec++; if ({bus.red_init, bus.red_n_row} !== '0 || bus.red_config_data !== '0) begin
            n_err++; $display("FAIL reset_init got init=%b row=%0d want 0", bus.red_init, bus.red_n_row); end
        n_vec++; if (bus.n_busy !== 3'd0 || bus.err_spurious !== 1'b0 || bus.cfg_ack !== 1'b1) begin
            n_err++; $display("FAIL reset_status got busy=%0d err=%b ack=%b want 0 0 1",
                              bus.n_busy, bus.err_spurious, bus.cfg_ack); end
        reset_n = 1'b1;
        tick();
        n_vec++; if (bus.red_init !== '0 || bus.out_valid !== 1'b0 || bus.cfg_ack !== 1'b1) begin
            n_err++; $display("FAIL reset_release got init=%b v=%b ack=%b want 0 0 1",
                              bus.red_init, bus.out_valid, bus.cfg_ack); end
    endtask

    task automatic test_alloc();
        logic [AW-1:0] d;
        do_reset();
        for (int i = 0; i < N; i++) begin
            d = rand_data();
            bus.cfg_valid = 1'b1;
            bus.cfg_row   = RW'(5 + i);
            bus.cfg_data  = d;
            n_vec++; if (bus.cfg_ack !== 1'b1) begin
                n_err++; $display("FAIL alloc_ack%0d got %b want 1", i, bus.cfg_ack); end
            tick();
            n_vec++; if (bus.red_init !== N'(1 << i) || bus.red_n_row !== RW'(5 + i) || bus.red_config_data !== d) begin
                n_err++; $display("FAIL alloc_init%0d got init=%b row=%0d want init=%b row=%0d",
                                  i, bus.red_init, bus.red_n_row, N'(1 << i), 5 + i); end
        end
        bus.cfg_row = RW'(9);
        n_vec++; if (bus.cfg_ack !== 1'b0 || bus.n_busy !== 3'd4) begin
            n_err++; $display("FAIL alloc_full got ack=%b busy=%0d want 0 4", bus.cfg_ack, bus.n_busy); end
        tick();
        n_vec++; if (bus.red_init !== '0 || bus.red_n_row !== RW'(8)) begin
            n_err++; $display("FAIL alloc_hold got init=%b row=%0d want 0 8", bus.red_init, bus.red_n_row); end
        bus.cfg_valid = 1'b0;
    endtask

    // Runs from the full pool left by test_alloc
    task automatic test_drain_single();
        bus.out_ack     = 1'b1;
        bus.red_sum_rdy = 4'b0100;
        set_sum(2, 32'h40490FDB, 2'd1);
        tick();
        bus.red_sum_rdy = '0;
        set_sum(2, 32'h0, 2'd0);
        n_vec++; if (bus.out_valid !== 1'b0 || bus.n_busy !== 3'd4) begin
            n_err++; $display("FAIL drain_early got v=%b busy=%0d want 0 4", bus.out_valid, bus.n_busy); end
        tick();
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 32'h40490FDB || bus.out_owner !== 2'd1 || bus.out_src !== 2'd2) begin
            n_err++; $display("FAIL drain_out got v=%b sum=%h own=%0d src=%0d want 1 40490fdb 1 2",
                              bus.out_valid, bus.out_sum, bus.out_owner, bus.out_src); end
        n_vec++; if (bus.cfg_ack !== 1'b1 || bus.n_busy !== 3'd3) begin
            n_err++; $display("FAIL drain_free got ack=%b busy=%0d want 1 3", bus.cfg_ack, bus.n_busy); end
        bus.cfg_valid = 1'b1;
        bus.cfg_row   = RW'(12);
        tick();
        bus.cfg_valid = 1'b0;
        n_vec++; if (bus.red_init !== 4'b0100 || bus.red_n_row !== RW'(12) || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL drain_realloc got init=%b row=%0d v=%b want 0100 12 0",
                              bus.red_init, bus.red_n_row, bus.out_valid); end
        bus.out_ack = 1'b0;
    endtask

    // All reducers finish together with the consumer always ready
    task automatic burst_order(input int first);
        int e;
        for (int k = 0; k < N; k++) set_sum(k, 32'h3F800000 + k, IW'(k ^ 3));
        bus.red_sum_rdy = '1;
        bus.out_ack     = 1'b1;
        tick();
        bus.red_sum_rdy = '0;
        tick();
        for (int i = 0; i < N; i++) begin
            e = (first + i) % N;
            n_vec++; if (bus.out_valid !== 1'b1 || bus.out_src !== IW'(e) || bus.out_sum !== 32'h3F800000 + e || bus.out_owner !== IW'(e ^ 3)) begin
                n_err++; $display("FAIL rr_order slot%0d got v=%b src=%0d sum=%h want src=%0d", i,
                                  bus.out_valid, bus.out_src, bus.out_sum, e); end
            tick();
        end
        n_vec++; if (bus.out_valid !== 1'b0 || bus.n_busy !== 3'd0) begin
            n_err++; $display("FAIL rr_empty got v=%b busy=%0d want 0 0", bus.out_valid, bus.n_busy); end
        bus.out_ack = 1'b0;
    endtask

    task automatic test_rr_order();
        do_reset();
        fill_pool();
        burst_order(0);
        // one result through reducer 0 moves the pointer to 1
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid   = 1'b0;
        bus.red_sum_rdy = 4'b0001;
        set_sum(0, 32'h12345678, 2'd3);
        bus.out_ack     = 1'b1;
        tick();
        bus.red_sum_rdy = '0;
        tick();
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd0 || bus.out_sum !== 32'h12345678) begin
            n_err++; $display("FAIL rr_single got v=%b src=%0d sum=%h want 1 0 12345678",
                              bus.out_valid, bus.out_src, bus.out_sum); end
        tick();
        fill_pool();
        burst_order(1);
    endtask

    task automatic test_stall();
        do_reset();
        fill_pool();
        for (int k = 0; k < N; k++) set_sum(k, 32'hC0000000 + k, IW'(N - 1 - k));
        bus.red_sum_rdy = '1;
        bus.out_ack     = 1'b0;
        tick();
        bus.red_sum_rdy = '0;
        tick();
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        n_vec++; if (bus.red_init !== 4'b0001) begin
            n_err++; $display("FAIL stall_refill got init=%b want 0001", bus.red_init); end
        for (int c = 0; c < 10; c++) begin
            n_vec++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd0 || bus.out_sum !== 32'hC0000000 || bus.out_owner !== 2'd3) begin
                n_err++; $display("FAIL stall_hold c%0d got v=%b src=%0d sum=%h own=%0d want 1 0 c0000000 3",
                                  c, bus.out_valid, bus.out_src, bus.out_sum, bus.out_owner); end
            n_vec++; if (bus.n_busy !== 3'd4 || bus.cfg_ack !== 1'b0) begin
                n_err++; $display("FAIL stall_pool c%0d got busy=%0d ack=%b want 4 0", c, bus.n_busy, bus.cfg_ack); end
            tick();
        end
        bus.out_ack = 1'b1;
        for (int i = 1; i < N; i++) begin
            tick();
            n_vec++; if (bus.out_valid !== 1'b1 || bus.out_src !== IW'(i) || bus.out_sum !== 32'hC0000000 + i || bus.out_owner !== IW'(N - 1 - i)) begin
                n_err++; $display("FAIL stall_drain%0d got v=%b src=%0d sum=%h want src=%0d",
                                  i, bus.out_valid, bus.out_src, bus.out_sum, i); end
        end
        tick();
        n_vec++; if (bus.out_valid !== 1'b0 || bus.n_busy !== 3'd1) begin
            n_err++; $display("FAIL stall_end got v=%b busy=%0d want 0 1", bus.out_valid, bus.n_busy); end
        bus.out_ack = 1'b0;
    endtask

    task automatic test_spurious();
        do_reset();
        set_sum(3, 32'hDEADBEEF, 2'd2);
        bus.red_sum_rdy = 4'b1000;
        tick();
        bus.red_sum_rdy = '0;
        n_vec++; if (bus.err_spurious !== 1'b1 || bus.out_valid !== 1'b0 || bus.n_busy !== 3'd0) begin
            n_err++; $display("FAIL spur_set got err=%b v=%b busy=%0d want 1 0 0",
                              bus.err_spurious, bus.out_valid, bus.n_busy); end
        repeat (4) tick();
        n_vec++; if (bus.err_spurious !== 1'b1 || bus.out_valid !== 1'b0 || bus.cfg_ack !== 1'b1) begin
            n_err++; $display("FAIL spur_sticky got err=%b v=%b ack=%b want 1 0 1",
                              bus.err_spurious, bus.out_valid, bus.cfg_ack); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill_pool();
        bus.out_ack     = 1'b0;
        set_sum(0, 32'hAAAA5555, 2'd2);
        bus.red_sum_rdy = 4'b0001;
        tick();
        bus.red_sum_rdy = '0;
        tick();
        set_sum(1, 32'h5555AAAA, 2'd1);
        bus.red_sum_rdy = 4'b0010;
        tick();
        bus.red_sum_rdy = '0;
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd0 || bus.n_busy !== 3'd3) begin
            n_err++; $display("FAIL midrst_pre got v=%b src=%0d busy=%0d want 1 0 3",
                              bus.out_valid, bus.out_src, bus.n_busy); end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++; if ({bus.out_valid, bus.out_sum, bus.out_owner, bus.out_src, bus.red_init, bus.red_n_row} !== '0 || bus.red_config_data !== '0) begin
            n_err++; $display("FAIL midrst_out got v=%b sum=%h init=%b row=%0d want all 0",
                              bus.out_valid, bus.out_sum, bus.red_init, bus.red_n_row); end
        n_vec++; if (bus.n_busy !== 3'd0 || bus.cfg_ack !== 1'b1 || bus.err_spurious !== 1'b0) begin
            n_err++; $display("FAIL midrst_status got busy=%0d ack=%b err=%b want 0 1 0",
                              bus.n_busy, bus.cfg_ack, bus.err_spurious); end
        tick();
        reset_n = 1'b1;
        tick();
        bus.cfg_valid = 1'b1;
        bus.cfg_row   = RW'(3);
        tick();
        bus.cfg_valid = 1'b0;
        n_vec++; if (bus.red_init !== 4'b0001 || bus.red_n_row !== RW'(3)) begin
            n_err++; $display("FAIL midrst_realloc got init=%b row=%0d want 0001 3", bus.red_init, bus.red_n_row); end
    endtask

    // Random traffic against a pool model: each reducer is idle, reducing, or waiting to be read
    task automatic test_random();
        int               st [N];      // 0 idle, 1 reducing, 2 result waiting
        int               nst [N];
        logic [FW-1:0]    rs [N];
        logic [IW-1:0]    ro [N];
        logic [FW-1:0]    dsum [N];
        logic [IW-1:0]    down [N];
        int               start, pick, cnt;
        logic             ov, err, exp_ack;
        logic [FW-1:0]    osum;
        logic [IW-1:0]    oown, osrc;
        logic [N-1:0]     init, sr;
        logic [RW-1:0]    row;
        logic [AW-1:0]    data;
        do_reset();
        for (int k = 0; k < N; k++) begin st[k] = 0; rs[k] = '0; ro[k] = '0; end
        start = 0; ov = 1'b0; err = 1'b0; osum = '0; oown = '0; osrc = '0;
        init = '0; row = '0; data = '0;
        for (int c = 0; c < 3000; c++) begin
            bus.cfg_valid = ($urandom_range(0, 1) == 1);
            bus.cfg_row   = RW'($urandom);
            bus.cfg_data  = rand_data();
            bus.out_ack   = ($urandom_range(0, 3) != 0);
            sr = '0;
            for (int k = 0; k < N; k++) begin
                dsum[k] = $urandom;
                down[k] = IW'($urandom);
                set_sum(k, dsum[k], down[k]);
                if (st[k] == 1 && $urandom_range(0, 2) == 0) sr[k] = 1'b1;
                else if ($urandom_range(0, 499) == 0)       sr[k] = 1'b1;
            end
            bus.red_sum_rdy = sr;
            pick = -1;
            for (int k = N - 1; k >= 0; k--) if (st[k] == 0) pick = k;
            exp_ack = (pick >= 0);
            n_vec++; if (bus.cfg_ack !== exp_ack) begin
                n_err++; $display("FAIL rnd_ack c%0d got %b want %b", c, bus.cfg_ack, exp_ack); end
            nst  = st;
            init = '0;
            if (bus.cfg_valid && pick >= 0) begin
                init[pick] = 1'b1; row = bus.cfg_row; data = bus.cfg_data; nst[pick] = 1;
            end
            for (int k = 0; k < N; k++) begin
                if (sr[k]) begin
                    if (st[k] == 1) begin nst[k] = 2; rs[k] = dsum[k]; ro[k] = down[k]; end
                    else err = 1'b1;
                end
            end
            if (!ov || bus.out_ack) begin
                pick = -1;
                for (int i = 0; i < N; i++) if (pick < 0 && st[(start + i) % N] == 2) pick = (start + i) % N;
                if (pick >= 0) begin
                    ov = 1'b1; osum = rs[pick]; oown = ro[pick]; osrc = IW'(pick);
                    nst[pick] = 0; start = (pick + 1) % N;
                end else begin
                    ov = 1'b0;
                end
            end
            tick();
            st  = nst;
            cnt = 0;
            for (int k = 0; k < N; k++) if (st[k] != 0) cnt++;
            n_vec++; if (bus.red_init !== init || bus.red_n_row !== row || bus.red_config_data !== data) begin
                n_err++; $display("FAIL rnd_init c%0d got init=%b row=%0d want init=%b row=%0d",
                                  c, bus.red_init, bus.red_n_row, init, row); end
            n_vec++; if (bus.out_valid !== ov || bus.out_sum !== osum || bus.out_owner !== oown || bus.out_src !== osrc) begin
                n_err++; $display("FAIL rnd_out c%0d got v=%b sum=%h own=%0d src=%0d want v=%b sum=%h own=%0d src=%0d",
                                  c, bus.out_valid, bus.out_sum, bus.out_owner, bus.out_src, ov, osum, oown, osrc); end
            n_vec++; if (bus.n_busy !== CW'(cnt) || bus.err_spurious !== err) begin
                n_err++; $display("FAIL rnd_status c%0d got busy=%0d err=%b want busy=%0d err=%b",
                                  c, bus.n_busy, bus.err_spurious, cnt, err); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_drain_single();
        test_rr_order();
        test_stall();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
